pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle controller.
- Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects RAW hazards and generates stall, bubble and forwarding selects for the 5-stage datapath.
- A mode parameter selects between full forwarding and stall-only hazard resolution.

Parameters:
- OPC_W, 11: opcode field width (instr[31:21]).
- REG_AW, 5: register address width.
- ZERO_REG, 31: hardwired-zero register; never a hazard or forwarding source.
- LINK_REG, 30: destination register forced for BL.
- EN_FWD, 1: 1 = forwarding plus load-use stall only; 0 = no forwarding, stall on any EX/MEM RAW hazard.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- instr_id  in  32  instruction currently in ID.
- id_valid  in  1  instr_id holds a real instruction.
- flush  in  1  squash the ID instruction (taken branch).
- stall_if  out  1  hold PC and IF/ID register this cycle.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  ctrl_t bundle for the stage.
- ex_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction.
- ex_rd, mem_rd, wb_rd  out  REG_AW each  destination register per stage.
- fwd_a, fwd_b  out  2 each  EX ALU operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - all valids, ctrl bundles and rd fields = 0; stall_if = 0; fwd_a = fwd_b = 00.
  - A reset asserted mid-operation discards all in-flight state on that edge.
- Decode (combinational, ID), same opcode map as the single-cycle controller:
  - ADDI, ADDS, B, B.LT, BL, BR, CBZ, LDUR, STUR, SUBS.
  - Unknown opcode produces the all-zero bundle (PASSB, no writes).
  - Decode adds uses_rn and uses_rm flags.
  - id_rn = instr[9:5].
  - id_rm = Reg2Loc ? instr[4:0] : instr[20:16].
  - id_rd = BL ? LINK_REG : instr[4:0].
- Advance: each edge, EX/MEM <= ID/EX and MEM/WB <= EX/MEM, unconditionally. ID/EX captures the decoded bundle, valid, rn, rm and rd.
- Hazard: a register r matches stage S when S_valid && S_ctrl.RegWrite && S_rd == r && r != ZERO_REG, and the ID instruction uses r (rn via uses_rn, rm via uses_rm).
  - EN_FWD=1: stall when EX matches and ex_ctrl.LDUR = 1 (load-use). Exactly one bubble per load-use.
  - EN_FWD=0: stall when EX or MEM matches. WB-stage hazards are resolved by regfile write-through, not by this block.
- Stall: stall_if = 1 combinationally in the same cycle; ID/EX loads a bubble (valid 0, bundle 0).
- Flush: ID/EX loads a bubble on the next edge.
  - flush overrides the stall bubble. stall_if is still driven from the hazard check.
  - Priority: reset > flush > stall > normal.
- id_valid = 0: treated as a bubble; never causes a stall.
- Forwarding (EN_FWD=1 only; else fwd = 00), computed from ID/EX rn/rm:
  - 01 if mem stage matches; else 10 if wb stage matches; else 00.
  - MEM takes priority over WB when both match the same register.
  - ZERO_REG never forwards.
- Bubble propagation: a bubble carries valid = 0 and never writes the regfile, memory or flags downstream.

Decomposition:
- Package pipe_pkg holds:
  - ctrl_t packed struct: Reg2Loc, Branch, Mem2Reg, ALUop[2:0], MemWrite, ALUSrc, RegWrite, Uncondbranch, setFlags, se_ctrl[1:0], BLT, BL, LDUR, uses_rn, uses_rm.
  - CTRL_W, the ALUop and se_ctrl encodings, and the opcode constants.
  - fwd select encodings FWD_RF/FWD_MEM/FWD_WB.
- Sub-module ctrl_decode: combinational opcode to ctrl_t mapping. It is independently testable.

Test Plan:
- Reset: assert reset for 2 cycles with ADDI streaming -> all valids 0, bundles 0, stall_if 0; first ADDI reaches ex_valid 1 cycle after release.
- Load-use: LDUR X1,[X2,#0] then ADDS X3,X1,X4 (EN_FWD=1) -> stall_if 1 for exactly 1 cycle, ex_valid 0 next cycle, then ADDS in EX with fwd_a = 10.
- Forwarding: ADDI X5,X0,#1; SUBS X6,X5,X5 -> SUBS in EX with fwd_a = fwd_b = 01, no stall. Repeat with X31 as dest -> fwd 00.
- Double match: ADDI X7; ADDI X7; ADDS X8,X7,X7 -> fwd_a = fwd_b = 01 (MEM wins over WB).
- Flush vs stall: load-use hazard with flush = 1 in the same cycle -> ID/EX bubble, and the squashed instruction never appears valid in any stage.
- EN_FWD=0: ADDI X9 then ADDS X10,X9,X9 -> stall_if 1 for 2 cycles, then ADDS issues with fwd 00. BL -> wb_rd = 30.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipelined controller: control bundle,
// ALU/sign-extend encodings, opcode match values and forwarding selects.
package pipe_pkg;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;

    localparam logic [1:0] SE_I  = 2'b00;
    localparam logic [1:0] SE_D  = 2'b01;
    localparam logic [1:0] SE_B  = 2'b10;
    localparam logic [1:0] SE_CB = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Opcodes are left-aligned in instr[31:21]; the mask keeps only the bits
    // that belong to the format's real opcode field.
    localparam logic [10:0] MASK_R  = 11'b11111111111;
    localparam logic [10:0] MASK_I  = 11'b11111111110;
    localparam logic [10:0] MASK_CB = 11'b11111111000;
    localparam logic [10:0] MASK_B  = 11'b11111100000;

    localparam logic [10:0] OPC_ADDI = 11'b10010001000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [10:0] OPC_B    = 11'b00010100000;
    localparam logic [10:0] OPC_BL   = 11'b10010100000;
    localparam logic [10:0] OPC_BLT  = 11'b01010100000;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100000;

    typedef struct packed {
        logic       Reg2Loc;
        logic       Branch;
        logic       Mem2Reg;
        logic [2:0] ALUop;
        logic       MemWrite;
        logic       ALUSrc;
        logic       RegWrite;
        logic       Uncondbranch;
        logic       setFlags;
        logic [1:0] se_ctrl;
        logic       BLT;
        logic       BL;
        logic       LDUR;
        logic       uses_rn;
        logic       uses_rm;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic opcMatch(input logic [10:0] opc,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (opc & mask) == val;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decode: opcode to ctrl_t plus the rn/rm/rd register
// addresses the hazard logic compares against.
module ctrl_decode
    import pipe_pkg::*;
#(
    parameter int OPC_W    = 11,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 30
) (
    input  logic [31:0]       instr,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] rn,
    output logic [REG_AW-1:0] rm,
    output logic [REG_AW-1:0] rd
);

    logic [OPC_W-1:0] w_opc;
    logic             w_unusedBits;

    assign w_opc        = instr[31 -: OPC_W];
    assign w_unusedBits = ^instr[15:10];

    always_comb begin
        ctrl = '0;
        if (opcMatch(w_opc, OPC_ADDI, MASK_I)) begin
            ctrl.ALUSrc   = 1'b1;
            ctrl.RegWrite = 1'b1;
            ctrl.ALUop    = ALU_ADD;
            ctrl.se_ctrl  = SE_I;
            ctrl.uses_rn  = 1'b1;
        end else if (opcMatch(w_opc, OPC_ADDS, MASK_R)) begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUop    = ALU_ADD;
            ctrl.setFlags = 1'b1;
            ctrl.uses_rn  = 1'b1;
            ctrl.uses_rm  = 1'b1;
        end else if (opcMatch(w_opc, OPC_SUBS, MASK_R)) begin
            ctrl.RegWrite = 1'b1;
            ctrl.ALUop    = ALU_SUB;
            ctrl.setFlags = 1'b1;
            ctrl.uses_rn  = 1'b1;
            ctrl.uses_rm  = 1'b1;
        end else if (opcMatch(w_opc, OPC_LDUR, MASK_R)) begin
            ctrl.ALUSrc   = 1'b1;
            ctrl.Mem2Reg  = 1'b1;
            ctrl.RegWrite = 1'b1;
            ctrl.ALUop    = ALU_ADD;
            ctrl.se_ctrl  = SE_D;
            ctrl.LDUR     = 1'b1;
            ctrl.uses_rn  = 1'b1;
        end else if (opcMatch(w_opc, OPC_STUR, MASK_R)) begin
            ctrl.Reg2Loc  = 1'b1;
            ctrl.ALUSrc   = 1'b1;
            ctrl.MemWrite = 1'b1;
            ctrl.ALUop    = ALU_ADD;
            ctrl.se_ctrl  = SE_D;
            ctrl.uses_rn  = 1'b1;
            ctrl.uses_rm  = 1'b1;
        end else if (opcMatch(w_opc, OPC_BR, MASK_R)) begin
            ctrl.Uncondbranch = 1'b1;
            ctrl.uses_rn      = 1'b1;
        end else if (opcMatch(w_opc, OPC_B, MASK_B)) begin
            ctrl.Uncondbranch = 1'b1;
            ctrl.se_ctrl      = SE_B;
        end else if (opcMatch(w_opc, OPC_BL, MASK_B)) begin
            ctrl.Uncondbranch = 1'b1;
            ctrl.RegWrite     = 1'b1;
            ctrl.BL           = 1'b1;
            ctrl.se_ctrl      = SE_B;
        end else if (opcMatch(w_opc, OPC_BLT, MASK_CB)) begin
            ctrl.BLT     = 1'b1;
            ctrl.se_ctrl = SE_CB;
        end else if (opcMatch(w_opc, OPC_CBZ, MASK_CB)) begin
            // CBZ tests Rt, which Reg2Loc steers onto the rm read port.
            ctrl.Reg2Loc = 1'b1;
            ctrl.Branch  = 1'b1;
            ctrl.se_ctrl = SE_CB;
            ctrl.uses_rm = 1'b1;
        end
    end

    assign rn = instr[5 +: REG_AW];
    assign rm = ctrl.Reg2Loc ? instr[0 +: REG_AW] : instr[16 +: REG_AW];
    assign rd = ctrl.BL ? REG_AW'(LINK_REG) : instr[0 +: REG_AW];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined controller: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// RAW hazard stall/bubble generation and EX operand forwarding selects.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int OPC_W    = 11,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int LINK_REG = 30,
    parameter int EN_FWD   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_id,
    input  logic              id_valid,
    input  logic              flush,
    output logic              stall_if,
    output ctrl_t             ex_ctrl,
    output ctrl_t             mem_ctrl,
    output ctrl_t             wb_ctrl,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [REG_AW-1:0] W_ZERO = REG_AW'(ZERO_REG);

    ctrl_t             w_idCtrl;
    logic [REG_AW-1:0] w_idRn, w_idRm, w_idRd;
    logic              w_exHit, w_memHit, w_stall;

    ctrl_t             r_exCtrl, r_memCtrl, r_wbCtrl;
    logic              r_exValid, r_memValid, r_wbValid;
    logic [REG_AW-1:0] r_exRn, r_exRm, r_exRd, r_memRd, r_wbRd;

    ctrl_decode #(
        .OPC_W    (OPC_W),
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .instr (instr_id),
        .ctrl  (w_idCtrl),
        .rn    (w_idRn),
        .rm    (w_idRm),
        .rd    (w_idRd)
    );

    function automatic logic stageHit(input logic              v,
                                      input ctrl_t             c,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
        return v && c.RegWrite && (rd == r) && (r != W_ZERO);
    endfunction

    assign w_exHit  = id_valid &&
                      ((w_idCtrl.uses_rn && stageHit(r_exValid, r_exCtrl, r_exRd, w_idRn)) ||
                       (w_idCtrl.uses_rm && stageHit(r_exValid, r_exCtrl, r_exRd, w_idRm)));
    assign w_memHit = id_valid &&
                      ((w_idCtrl.uses_rn && stageHit(r_memValid, r_memCtrl, r_memRd, w_idRn)) ||
                       (w_idCtrl.uses_rm && stageHit(r_memValid, r_memCtrl, r_memRd, w_idRm)));

    // With forwarding only a load in EX is too late to bypass; without it any
    // producer still in EX or MEM must drain to the regfile first.
    assign w_stall  = (EN_FWD != 0) ? (w_exHit && r_exCtrl.LDUR) : (w_exHit || w_memHit);
    assign stall_if = w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exCtrl   <= '0;
            r_memCtrl  <= '0;
            r_wbCtrl   <= '0;
            r_exValid  <= 1'b0;
            r_memValid <= 1'b0;
            r_wbValid  <= 1'b0;
            r_exRn     <= '0;
            r_exRm     <= '0;
            r_exRd     <= '0;
            r_memRd    <= '0;
            r_wbRd     <= '0;
        end else begin
            r_memCtrl  <= r_exCtrl;
            r_memValid <= r_exValid;
            r_memRd    <= r_exRd;
            r_wbCtrl   <= r_memCtrl;
            r_wbValid  <= r_memValid;
            r_wbRd     <= r_memRd;
            if (flush || w_stall || !id_valid) begin
                r_exCtrl  <= '0;
                r_exValid <= 1'b0;
                r_exRn    <= '0;
                r_exRm    <= '0;
                r_exRd    <= '0;
            end else begin
                r_exCtrl  <= w_idCtrl;
                r_exValid <= 1'b1;
                r_exRn    <= w_idRn;
                r_exRm    <= w_idRm;
                r_exRd    <= w_idRd;
            end
        end
    end

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (EN_FWD != 0) begin
            if (r_exCtrl.uses_rn) begin
                if (stageHit(r_memValid, r_memCtrl, r_memRd, r_exRn))
                    fwd_a = FWD_MEM;
                else if (stageHit(r_wbValid, r_wbCtrl, r_wbRd, r_exRn))
                    fwd_a = FWD_WB;
            end
            if (r_exCtrl.uses_rm) begin
                if (stageHit(r_memValid, r_memCtrl, r_memRd, r_exRm))
                    fwd_b = FWD_MEM;
                else if (stageHit(r_wbValid, r_wbCtrl, r_wbRd, r_exRm))
                    fwd_b = FWD_WB;
            end
        end
    end

    assign ex_ctrl   = r_exCtrl;
    assign mem_ctrl  = r_memCtrl;
    assign wb_ctrl   = r_wbCtrl;
    assign ex_valid  = r_exValid;
    assign mem_valid = r_memValid;
    assign wb_valid  = r_wbValid;
    assign ex_rd     = r_exRd;
    assign mem_rd    = r_memRd;
    assign wb_rd     = r_wbRd;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one forwarding instance and one stall-only
// instance share the ID stimulus; each scenario checks the relevant instance.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_id = '0;
    logic        id_valid = 1'b0;
    logic        flush = 1'b0;

    logic        f_stall, s_stall;
    ctrl_t       f_exCtrl, f_memCtrl, f_wbCtrl, s_exCtrl, s_memCtrl, s_wbCtrl;
    logic        f_exV, f_memV, f_wbV, s_exV, s_memV, s_wbV;
    logic [4:0]  f_exRd, f_memRd, f_wbRd, s_exRd, s_memRd, s_wbRd;
    logic [1:0]  f_fwdA, f_fwdB, s_fwdA, s_fwdB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.EN_FWD(1)) u_dutF (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid), .flush(flush),
        .stall_if(f_stall), .ex_ctrl(f_exCtrl), .mem_ctrl(f_memCtrl), .wb_ctrl(f_wbCtrl),
        .ex_valid(f_exV), .mem_valid(f_memV), .wb_valid(f_wbV),
        .ex_rd(f_exRd), .mem_rd(f_memRd), .wb_rd(f_wbRd), .fwd_a(f_fwdA), .fwd_b(f_fwdB)
    );

    pipe_ctrl #(.EN_FWD(0)) u_dutS (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid), .flush(flush),
        .stall_if(s_stall), .ex_ctrl(s_exCtrl), .mem_ctrl(s_memCtrl), .wb_ctrl(s_wbCtrl),
        .ex_valid(s_exV), .mem_valid(s_memV), .wb_valid(s_wbV),
        .ex_rd(s_exRd), .mem_rd(s_memRd), .wb_rd(s_wbRd), .fwd_a(s_fwdA), .fwd_b(s_fwdB)
    );

    function automatic logic [31:0] encAddi(input logic [4:0] rd, input logic [4:0] rn, input logic [11:0] imm);
        return {10'b1001000100, imm, rn, rd};
    endfunction

    function automatic logic [31:0] encR(input logic [10:0] opc, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        return {opc, rm, 6'b000000, rn, rd};
    endfunction

    function automatic logic [31:0] encD(input logic [10:0] opc, input logic [4:0] rt, input logic [4:0] rn, input logic [8:0] addr);
        return {opc, addr, 2'b00, rn, rt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        id_valid = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        id_valid = 1'b1;
        instr_id = encAddi(5'd1, 5'd0, 12'd1);
        tick();
        tick();
        #1;
        checks++;
        if ({f_exV, f_memV, f_wbV} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_valids got=%b exp=000", {f_exV, f_memV, f_wbV});
        end
        checks++;
        if ({f_exCtrl, f_memCtrl, f_wbCtrl} !== '0) begin
            failures++; $display("[TB] FAIL reset_ctrl got=%h exp=0", {f_exCtrl, f_memCtrl, f_wbCtrl});
        end
        checks++;
        if ({f_exRd, f_memRd, f_wbRd, f_stall, f_fwdA, f_fwdB} !== '0) begin
            failures++; $display("[TB] FAIL reset_misc got=%h exp=0", {f_exRd, f_memRd, f_wbRd, f_stall, f_fwdA, f_fwdB});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (f_exV !== 1'b1 || f_exRd !== 5'd1) begin
            failures++; $display("[TB] FAIL reset_release got=%b/%0d exp=1/1", f_exV, f_exRd);
        end
        checks++;
        if (f_exCtrl.ALUSrc !== 1'b1 || f_exCtrl.RegWrite !== 1'b1 || f_exCtrl.ALUop !== 3'b001) begin
            failures++; $display("[TB] FAIL addi_decode got=%h", f_exCtrl);
        end
        drain();
    endtask

    task automatic test_decode();
        id_valid = 1'b1;
        instr_id = encD(11'b11111000010, 5'd1, 5'd2, 9'd8);
        tick();
        checks++;
        if (f_exCtrl.LDUR !== 1'b1 || f_exCtrl.Mem2Reg !== 1'b1 || f_exRd !== 5'd1) begin
            failures++; $display("[TB] FAIL ldur_decode got=%h rd=%0d", f_exCtrl, f_exRd);
        end
        id_valid = 1'b0;
        instr_id = encR(11'b10101011000, 5'd3, 5'd1, 5'd1);
        #1;
        checks++;
        if (f_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL idle_no_stall got=%b exp=0", f_stall);
        end
        id_valid = 1'b1;
        instr_id = encD(11'b11111000000, 5'd5, 5'd2, 9'd0);
        tick();
        checks++;
        if (f_exCtrl.MemWrite !== 1'b1 || f_exCtrl.RegWrite !== 1'b0 || f_exRd !== 5'd5) begin
            failures++; $display("[TB] FAIL stur_decode got=%h rd=%0d", f_exCtrl, f_exRd);
        end
        instr_id = 32'h0000_0000;
        tick();
        checks++;
        if (f_exV !== 1'b1 || f_exCtrl !== '0) begin
            failures++; $display("[TB] FAIL unknown_decode got=%b/%h exp=1/0", f_exV, f_exCtrl);
        end
        drain();
    endtask

    task automatic test_load_use();
        id_valid = 1'b1;
        instr_id = encD(11'b11111000010, 5'd1, 5'd2, 9'd0);
        tick();
        instr_id = encR(11'b10101011000, 5'd3, 5'd1, 5'd4);
        #1;
        checks++;
        if (f_stall !== 1'b1) begin
            failures++; $display("[TB] FAIL lu_stall got=%b exp=1", f_stall);
        end
        tick();
        checks++;
        if (f_exV !== 1'b0 || f_memV !== 1'b1) begin
            failures++; $display("[TB] FAIL lu_bubble got=%b/%b exp=0/1", f_exV, f_memV);
        end
        #1;
        checks++;
        if (f_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL lu_one_stall got=%b exp=0", f_stall);
        end
        tick();
        checks++;
        if (f_exV !== 1'b1 || f_exRd !== 5'd3 || f_fwdA !== 2'b10 || f_fwdB !== 2'b00) begin
            failures++; $display("[TB] FAIL lu_fwd got=%b/%0d/%b/%b exp=1/3/10/00", f_exV, f_exRd, f_fwdA, f_fwdB);
        end
        drain();
    endtask

    task automatic test_forward();
        id_valid = 1'b1;
        instr_id = encAddi(5'd5, 5'd0, 12'd1);
        tick();
        instr_id = encR(11'b11101011000, 5'd6, 5'd5, 5'd5);
        #1;
        checks++;
        if (f_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL fwd_no_stall got=%b exp=0", f_stall);
        end
        tick();
        checks++;
        if (f_exRd !== 5'd6 || f_fwdA !== 2'b01 || f_fwdB !== 2'b01) begin
            failures++; $display("[TB] FAIL fwd_mem got=%0d/%b/%b exp=6/01/01", f_exRd, f_fwdA, f_fwdB);
        end
        drain();
        id_valid = 1'b1;
        instr_id = encAddi(5'd31, 5'd0, 12'd1);
        tick();
        instr_id = encR(11'b11101011000, 5'd6, 5'd31, 5'd31);
        tick();
        checks++;
        if (f_memV !== 1'b1 || f_memRd !== 5'd31 || f_fwdA !== 2'b00 || f_fwdB !== 2'b00) begin
            failures++; $display("[TB] FAIL fwd_zero got=%b/%0d/%b/%b exp=1/31/00/00", f_memV, f_memRd, f_fwdA, f_fwdB);
        end
        drain();
    endtask

    task automatic test_double_match();
        id_valid = 1'b1;
        instr_id = encAddi(5'd7, 5'd0, 12'd1);
        tick();
        instr_id = encAddi(5'd7, 5'd7, 12'd2);
        tick();
        instr_id = encR(11'b10101011000, 5'd8, 5'd7, 5'd7);
        tick();
        checks++;
        if (f_memRd !== 5'd7 || f_wbRd !== 5'd7 || f_fwdA !== 2'b01 || f_fwdB !== 2'b01) begin
            failures++; $display("[TB] FAIL double_match got=%0d/%0d/%b/%b exp=7/7/01/01", f_memRd, f_wbRd, f_fwdA, f_fwdB);
        end
        drain();
    endtask

    task automatic test_flush_stall();
        id_valid = 1'b1;
        instr_id = encD(11'b11111000010, 5'd1, 5'd2, 9'd0);
        tick();
        instr_id = encR(11'b10101011000, 5'd3, 5'd1, 5'd4);
        flush = 1'b1;
        #1;
        checks++;
        if (f_stall !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_stall_if got=%b exp=1", f_stall);
        end
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        checks++;
        if (f_exV !== 1'b0 || f_exCtrl !== '0) begin
            failures++; $display("[TB] FAIL flush_bubble got=%b/%h exp=0/0", f_exV, f_exCtrl);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (((f_exV && f_exRd == 5'd3) || (f_memV && f_memRd == 5'd3) || (f_wbV && f_wbRd == 5'd3)) !== 1'b0) begin
                failures++; $display("[TB] FAIL flush_squashed cycle=%0d got=1 exp=0", i);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_no_forward();
        id_valid = 1'b1;
        instr_id = encAddi(5'd9, 5'd0, 12'd1);
        tick();
        instr_id = encR(11'b10101011000, 5'd10, 5'd9, 5'd9);
        #1;
        checks++;
        if (s_stall !== 1'b1) begin
            failures++; $display("[TB] FAIL nofwd_stall1 got=%b exp=1", s_stall);
        end
        tick();
        checks++;
        if (s_stall !== 1'b1 || s_exV !== 1'b0) begin
            failures++; $display("[TB] FAIL nofwd_stall2 got=%b/%b exp=1/0", s_stall, s_exV);
        end
        tick();
        checks++;
        if (s_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL nofwd_release got=%b exp=0", s_stall);
        end
        tick();
        checks++;
        if (s_exV !== 1'b1 || s_exRd !== 5'd10 || s_fwdA !== 2'b00 || s_fwdB !== 2'b00) begin
            failures++; $display("[TB] FAIL nofwd_issue got=%b/%0d/%b/%b exp=1/10/00/00", s_exV, s_exRd, s_fwdA, s_fwdB);
        end
        drain();
        id_valid = 1'b1;
        instr_id = {6'b100101, 26'd4};
        tick();
        id_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (s_wbV !== 1'b1 || s_wbRd !== 5'd30 || s_wbCtrl.BL !== 1'b1 || s_wbCtrl.RegWrite !== 1'b1) begin
            failures++; $display("[TB] FAIL bl_link got=%b/%0d/%h exp=1/30", s_wbV, s_wbRd, s_wbCtrl);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        id_valid = 1'b1;
        instr_id = encAddi(5'd12, 5'd0, 12'd3);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({f_exV, f_memV, f_wbV, s_exV, s_memV, s_wbV} !== 6'b0 || f_memCtrl !== '0) begin
            failures++; $display("[TB] FAIL reset_mid got=%b/%h exp=0/0", {f_exV, f_memV, f_wbV, s_exV, s_memV, s_wbV}, f_memCtrl);
        end
        reset = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_forward();
        test_double_match();
        test_flush_stall();
        test_no_forward();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
